// File: rtl/iob_vexriscv_bus_merge_if.sv
// Bundles the bus signals of the two-master, one-slave merge block.
//   ibus_req/ibus_resp : instruction master request {valid,addr,wdata,wstrb} / response {rdata,ready}
//   dbus_req/dbus_resp : data master request / response (same layout)
//   mem_req/mem_resp   : merged slave request / slave response
// Modport "slave" is the arbiter's view (it answers the masters and drives the memory);
// modport "master" is the environment's view (drives both masters and the slave response).
interface iob_vexriscv_bus_merge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
  parameter int RESP_W = DATA_W + 1
);
  logic [REQ_W-1:0]  ibus_req;
  logic [RESP_W-1:0] ibus_resp;
  logic [REQ_W-1:0]  dbus_req;
  logic [RESP_W-1:0] dbus_resp;
  logic [REQ_W-1:0]  mem_req;
  logic [RESP_W-1:0] mem_resp;

  modport slave (
    input  ibus_req,
    input  dbus_req,
    input  mem_resp,
    output ibus_resp,
    output dbus_resp,
    output mem_req
  );

  modport master (
    output ibus_req,
    output dbus_req,
    output mem_resp,
    input  ibus_resp,
    input  dbus_resp,
    input  mem_req
  );
endinterface

// File: rtl/iob_vexriscv_bus_merge.sv
// Round-robin merge of the VexRiscv instruction and data buses onto one
// native memory port. One transaction is outstanding at a time; the winning
// request is registered onto mem_req and the slave's ready pulse is routed
// back to the granted master in the same cycle.
// Ports:
//   clk    : clock, all state on the rising edge
//   rst    : asynchronous active-high reset
//   bus_io : ibus/dbus request+response, merged mem request+response
module iob_vexriscv_bus_merge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
  parameter int RESP_W = DATA_W + 1
) (
  input logic                     clk,
  input logic                     rst,
  iob_vexriscv_bus_merge_if.slave bus_io
);

  localparam int PAY_W = REQ_W - 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IBUS = 2'b01,
    GNT_DBUS = 2'b10
  } grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  // 1 when dbus held the most recent grant; reset value 0 lets dbus win the first tie
  logic              last_dbus_q, last_dbus_d;
  logic [REQ_W-1:0]  mem_req_q, mem_req_d;
  logic              pick_dbus;

  logic              ibus_vld;
  logic              dbus_vld;
  logic [PAY_W-1:0]  ibus_pay;
  logic [PAY_W-1:0]  dbus_pay;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_rdata;

  assign ibus_vld  = bus_io.ibus_req[REQ_W-1];
  assign dbus_vld  = bus_io.dbus_req[REQ_W-1];
  assign ibus_pay  = bus_io.ibus_req[PAY_W-1:0];
  assign dbus_pay  = bus_io.dbus_req[PAY_W-1:0];
  assign mem_rdy   = bus_io.mem_resp[0];
  assign mem_rdata = bus_io.mem_resp[RESP_W-1:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      last_dbus_q <= 1'b0;
      mem_req_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_dbus_q <= last_dbus_d;
      mem_req_q   <= mem_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_dbus_d = last_dbus_q;
    mem_req_d   = mem_req_q;
    // dbus wins when it is alone, or on a tie when ibus was served last
    pick_dbus   = dbus_vld && (!ibus_vld || !last_dbus_q);

    unique case (state_q)
      IDLE: begin
        if (ibus_vld || dbus_vld) begin
          mem_req_d   = {1'b1, (pick_dbus ? dbus_pay : ibus_pay)};
          grant_d     = pick_dbus ? GNT_DBUS : GNT_IBUS;
          last_dbus_d = pick_dbus;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Master inputs are ignored here; only the slave's ready ends the transfer.
        if (mem_rdy) begin
          mem_req_d = '0;
          grant_d   = GNT_NONE;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_io.mem_req = mem_req_q;

  // Ready is gated by BUSY so a stray slave ready while idle reaches nobody.
  assign bus_io.ibus_resp = {mem_rdata, mem_rdy && (state_q == BUSY) && (grant_q == GNT_IBUS)};
  assign bus_io.dbus_resp = {mem_rdata, mem_rdy && (state_q == BUSY) && (grant_q == GNT_DBUS)};

endmodule

// File: doc/iob_vexriscv_bus_merge.md
# iob_vexriscv_bus_merge

Two-master, one-slave native-bus arbiter that sits directly downstream of the VexRiscv wrapper. It merges the wrapper's instruction and data request buses onto a single memory/interconnect port, registers the winning request, and routes the response back to the requester. Masters are granted round-robin and only one transaction is outstanding at a time. It is intended for single-port SRAM or boot-memory systems where ibus and dbus cannot have separate ports.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- REQ_W, 1+ADDR_W+DATA_W+DATA_W/8, request bundle {valid, addr, wdata, wstrb}, valid is MSB
- RESP_W, DATA_W+1, response bundle {rdata, ready}, ready is LSB

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ibus_req  in  REQ_W  instruction-master request (wstrb always 0)
- ibus_resp  out  RESP_W  instruction-master response
- dbus_req  in  REQ_W  data-master request; wstrb!=0 means write
- dbus_resp  out  RESP_W  data-master response
- mem_req  out  REQ_W  merged request to slave, fully registered
- mem_resp  in  RESP_W  slave response; ready is a one-cycle pulse per transaction

## Operation
- State machine has two states.
  - IDLE: mem_req.valid=0.
    - If exactly one master's valid is high, grant it.
    - If both are high, grant the master not granted last (round-robin via last_grant register).
    - On grant, capture the master's addr/wdata/wstrb into mem_req, set mem_req.valid=1, record grant, update last_grant, and go to BUSY.
    - No valid high: stay in IDLE.
  - BUSY: hold mem_req constant. Master inputs are not sampled.
    - When mem_resp.ready=1, clear mem_req.valid (whole mem_req to 0) at that edge and return to IDLE.
- Response routing (combinational from mem_resp):
  - granted_resp.ready = mem_resp.ready & BUSY & (grant==that master).
  - Non-granted master's ready=0.
  - rdata = mem_resp.rdata on both resp buses.
  - Read data and write completion both use the same ready pulse.
- Slave ready while IDLE: ignored, no response to either master.
- A master dropping valid while granted is a protocol violation. The transaction still completes and its ready pulse is still delivered.
- Reset (any time, including mid-transaction): state=IDLE, mem_req=0, grant=none, last_grant=ibus, so dbus wins the first tie. Both resp ready outputs read 0 during and after reset.

## Timing
- Cycle 0: master valid sampled in IDLE.
- Cycle 1: mem_req.valid=1 with captured payload. This is a one-cycle request latency.
- Cycle k≥1: slave ready pulse. The master's ready and rdata appear in the same cycle k (zero response latency).
- Cycle k+1: IDLE. mem_req.valid=0 for at least this cycle, so the slave never sees a stale repeat valid. The arbiter samples masters again here.
- Minimum transaction period is 2 cycles for a zero-wait slave (ready at k=1); back-to-back throughput is one transaction per k+1 cycles.
- A master held valid across its own ready cycle is not re-issued. Re-issue happens only if valid is still high in cycle k+1, which is a new request by protocol.
- Under continuous contention, grants alternate strictly: dbus, ibus, dbus, ibus, and so on.

## Test plan
- Reset, then ibus addr=0x100 only, slave ready 1 cycle after valid -> mem_req={1,0x100,0,0} at cycle 1; ibus_resp.ready=1 with rdata=0x00000013 at cycle 2; dbus_resp.ready stays 0.
- dbus write addr=0x2004, wdata=0xDEADBEEF, wstrb=0xF, slave wait 3 cycles -> mem_req held stable for 4 cycles; single dbus ready pulse; mem_req.valid=0 on the next cycle.
- Both masters valid continuously from reset, 8 transactions -> grant order D,I,D,I,D,I,D,I, and each master receives exactly 4 ready pulses.
- Slave asserts spurious ready while IDLE -> neither resp ready rises and state remains IDLE.
- Assert rst two cycles into a BUSY dbus read with slave stalled -> mem_req=0 immediately (asynchronous reset), no ready to any master, and the next contended grant goes to dbus.
- Byte store, wstrb=0x4 at addr 0x3002 -> mem_req wstrb=0x4 and addr=0x3002 passed unmodified.
